// File: rtl/contador_rolhas_pkg.sv
// Shared definitions for the cork counter / corking station.
package contador_rolhas_pkg;

  // Corking station states
  typedef enum logic [1:0] {
    OCIOSO,
    SEM_ROLHA,
    VEDANDO,
    AGUARDA_SAIDA
  } estado_t;

  // Count ceiling, the same ceiling the dispenser uses
  localparam int CONTAGEM_MAX = 99;

  // Width of the cork count bus
  localparam int LARGURA_CONTAGEM = 7;

  // Width of the corked-bottle total
  localparam int LARGURA_TOTAL = 10;

  // Clamp a load value to the count ceiling
  function automatic logic [LARGURA_CONTAGEM-1:0] satura_carga(
    input logic [LARGURA_CONTAGEM-1:0] valor,
    input logic [LARGURA_CONTAGEM-1:0] maximo
  );
    return (valor > maximo) ? maximo : valor;
  endfunction

endpackage

// File: rtl/contador_rolhas_bin2bcd_7.sv
// Combinational 7-bit binary to two-digit BCD converter (valid for 0..99).
module bin2bcd_7 (
  input  logic [6:0] bin,
  output logic [3:0] dezena,
  output logic [3:0] unidade
);

  // Tens and units digits; inputs above 99 are outside the valid range
  assign dezena  = 4'(bin / 7'd10);
  assign unidade = 4'(bin % 7'd10);

endmodule

// File: rtl/contador_rolhas.sv
// Cork counter and corking-station controller: holds the cork count loaded
// by the dispenser, consumes one cork per bottle and drives the corker.
module contador_rolhas #(
  parameter int CICLOS_VEDACAO = 4,
  parameter int CONTAGEM_MAX   = contador_rolhas_pkg::CONTAGEM_MAX,
  parameter int LIMITE_ALERTA  = 5
) (
  input  logic                                          CLOCK,
  input  logic                                          RESET,
  input  logic                                          LOAD_CONTADOR,
  input  logic [contador_rolhas_pkg::LARGURA_CONTAGEM-1:0] VALOR_CARGA,
  input  logic                                          GARRAFA_PRESENTE,
  output logic [contador_rolhas_pkg::LARGURA_CONTAGEM-1:0] COUNT_ATUAL,
  output logic                                          VEDADOR_ATIVO,
  output logic                                          GARRAFA_VEDADA,
  output logic                                          FALTA_ROLHA,
  output logic                                          ALERTA_BAIXO,
  output logic [3:0]                                    DEZENA,
  output logic [3:0]                                    UNIDADE,
  output logic [contador_rolhas_pkg::LARGURA_TOTAL-1:0]    TOTAL_VEDADAS
);

  import contador_rolhas_pkg::*;

  localparam int LC = LARGURA_CONTAGEM;
  localparam int LT = LARGURA_TOTAL;
  localparam int LARGURA_TIMER = (CICLOS_VEDACAO > 1) ? $clog2(CICLOS_VEDACAO) : 1;

  localparam logic [LC-1:0]            MAX_CONTAGEM  = LC'(CONTAGEM_MAX);
  localparam logic [LC-1:0]            LIMITE        = LC'(LIMITE_ALERTA);
  localparam logic [LT-1:0]            TOTAL_MAX     = '1;
  localparam logic [LARGURA_TIMER-1:0] TIMER_INICIAL = LARGURA_TIMER'(CICLOS_VEDACAO - 1);

  estado_t                  estado_reg;
  logic [LC-1:0]            count_reg;
  logic [LT-1:0]            total_reg;
  logic [LARGURA_TIMER-1:0] timer_reg;
  logic                     vedador_reg;
  logic                     vedada_reg;
  logic                     falta_reg;

  logic [LC-1:0] carga_sat;
  logic [LC-1:0] contagem_efetiva;
  logic          consome;

  // Count seen by the FSM this cycle: a same-cycle load takes precedence
  assign carga_sat        = satura_carga(VALOR_CARGA, MAX_CONTAGEM);
  assign contagem_efetiva = LOAD_CONTADOR ? carga_sat : count_reg;

  // A cork is taken only when a waiting bottle meets a non-zero effective count
  assign consome = GARRAFA_PRESENTE && (contagem_efetiva != '0) &&
                   ((estado_reg == OCIOSO) || (estado_reg == SEM_ROLHA));

  // Count register: load, then subtract the consumed cork (never below 0)
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count_reg <= '0;
    end else begin
      count_reg <= consome ? (contagem_efetiva - LC'(1)) : contagem_efetiva;
    end
  end

  // Corking FSM with registered actuator, pulse, shortage flag and total
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      estado_reg  <= AGUARDA_SAIDA;
      timer_reg   <= '0;
      vedador_reg <= 1'b0;
      vedada_reg  <= 1'b0;
      falta_reg   <= 1'b0;
      total_reg   <= '0;
    end else begin
      vedada_reg <= 1'b0;
      case (estado_reg)
        OCIOSO: begin
          if (consome) begin
            estado_reg  <= VEDANDO;
            timer_reg   <= TIMER_INICIAL;
            vedador_reg <= 1'b1;
          end else if (GARRAFA_PRESENTE) begin
            estado_reg <= SEM_ROLHA;
            falta_reg  <= 1'b1;
          end
        end
        SEM_ROLHA: begin
          if (!GARRAFA_PRESENTE) begin
            estado_reg <= OCIOSO;
            falta_reg  <= 1'b0;
          end else if (consome) begin
            estado_reg  <= VEDANDO;
            timer_reg   <= TIMER_INICIAL;
            vedador_reg <= 1'b1;
            falta_reg   <= 1'b0;
          end
        end
        VEDANDO: begin
          // Bottle removal is ignored here: the cork is already spent
          if (timer_reg == '0) begin
            estado_reg  <= AGUARDA_SAIDA;
            vedador_reg <= 1'b0;
            vedada_reg  <= 1'b1;
            if (total_reg != TOTAL_MAX) begin
              total_reg <= total_reg + LT'(1);
            end
          end else begin
            timer_reg <= timer_reg - LARGURA_TIMER'(1);
          end
        end
        AGUARDA_SAIDA: begin
          // The same bottle must leave before another one can be corked
          if (!GARRAFA_PRESENTE) begin
            estado_reg <= OCIOSO;
          end
        end
        default: begin
          estado_reg <= AGUARDA_SAIDA;
        end
      endcase
    end
  end

  assign COUNT_ATUAL    = count_reg;
  assign VEDADOR_ATIVO  = vedador_reg;
  assign GARRAFA_VEDADA = vedada_reg;
  assign FALTA_ROLHA    = falta_reg;
  assign TOTAL_VEDADAS  = total_reg;
  assign ALERTA_BAIXO   = (count_reg <= LIMITE);

  bin2bcd_7 u_bcd (
    .bin     (count_reg),
    .dezena  (DEZENA),
    .unidade (UNIDADE)
  );

endmodule

// File: doc/contador_rolhas.md
Name: contador_rolhas

Overview:
Cork counter and corking-station controller for the bottling line. It is the receiving end of the dispenser's load interface: it accepts LOAD_CONTADOR/VALOR_CARGA, holds the current cork count, and returns it to the dispenser as COUNT_ATUAL. It consumes one cork per bottle through a corking FSM and drives the corker actuator, the status flags and the BCD display digits.

Parameters:
CICLOS_VEDACAO, 4, number of cycles the corker actuator stays active per bottle (≥1)
CONTAGEM_MAX, 99, saturation ceiling of the cork count
LIMITE_ALERTA, 5, count at or below which ALERTA_BAIXO is asserted

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
LOAD_CONTADOR  in  1  one-cycle load strobe from the dispenser
VALOR_CARGA  in  7  value to load when LOAD_CONTADOR=1
GARRAFA_PRESENTE  in  1  bottle positioned under the corker (level, synchronous)
COUNT_ATUAL  out  7  current cork count, 0..99, registered
VEDADOR_ATIVO  out  1  corker actuator enable
GARRAFA_VEDADA  out  1  one-cycle pulse when a bottle finishes corking
FALTA_ROLHA  out  1  bottle waiting with no cork available
ALERTA_BAIXO  out  1  COUNT_ATUAL ≤ LIMITE_ALERTA
DEZENA  out  4  BCD tens digit of COUNT_ATUAL
UNIDADE  out  4  BCD units digit of COUNT_ATUAL
TOTAL_VEDADAS  out  10  bottles corked since reset, saturates at 1023

Behaviour:
- Reset: RESET is asynchronous and active-high; the clock is CLOCK. Reset values:
  - COUNT_ATUAL=0, TOTAL_VEDADAS=0.
  - VEDADOR_ATIVO, GARRAFA_VEDADA and FALTA_ROLHA are 0.
  - The FSM starts in AGUARDA_SAIDA, so a bottle still present when reset is applied is never re-corked.
  - ALERTA_BAIXO=1 after reset because the count is 0.
- Count register, priority per cycle:
  - Load and consume in the same cycle: COUNT_ATUAL ← min(VALOR_CARGA, CONTAGEM_MAX) − 1, saturating at 0.
  - Load only: COUNT_ATUAL ← min(VALOR_CARGA, CONTAGEM_MAX). Values 100..127 clamp to 99.
  - Consume only: COUNT_ATUAL ← COUNT_ATUAL − 1. The FSM never consumes at 0.
  - At most one consume occurs per cycle.
- FSM states:
  - OCIOSO:
    - GARRAFA_PRESENTE=1 and the effective count>0 → VEDANDO. Consume one cork and load the timer with CICLOS_VEDACAO−1.
    - GARRAFA_PRESENTE=1 and count=0 → SEM_ROLHA.
  - SEM_ROLHA:
    - FALTA_ROLHA=1 while in this state.
    - Count becomes >0, for example after a load → VEDANDO, consuming as above.
    - GARRAFA_PRESENTE=0 → OCIOSO with no consume.
  - VEDANDO:
    - VEDADOR_ATIVO=1 for exactly CICLOS_VEDACAO cycles.
    - When the timer reaches 0 → AGUARDA_SAIDA. GARRAFA_VEDADA pulses for 1 cycle on that transition and TOTAL_VEDADAS increments, saturating.
    - A bottle removed mid-corking does not abort the sequence; the cork is already consumed.
  - AGUARDA_SAIDA:
    - Wait for GARRAFA_PRESENTE=0 → OCIOSO. This prevents double corking of the same bottle.
- "Effective count" in OCIOSO is the value after any same-cycle load, so a bottle arriving together with a load from 0 is corked without passing through SEM_ROLHA.
- All outputs are registered except ALERTA_BAIXO, DEZENA and UNIDADE, which are combinational decodes of the COUNT_ATUAL register. DEZENA=COUNT/10 and UNIDADE=COUNT%10, both valid for 0..99.
- Latency:
  - A bottle edge in OCIOSO gives VEDADOR_ATIVO=1 and the decremented count on the next clock.
  - GARRAFA_VEDADA rises CICLOS_VEDACAO cycles after VEDADOR_ATIVO rises.
- Reset mid-corking: the actuator drops immediately and the consumed cork is not restored.

Decomposition:
- Shared package:
  - FSM state enum: OCIOSO, SEM_ROLHA, VEDANDO, AGUARDA_SAIDA.
  - Constant CONTAGEM_MAX=99, shared with the dispenser's 99 ceiling.
  - Width constant 7 for the count bus.
- One sub-module, bin2bcd_7: a combinational 7-bit binary to two-digit BCD converter, reusable by other display blocks.

Test Plan:
- Reset, then bottle held present at 0 corks → AGUARDA_SAIDA; remove bottle, re-present → SEM_ROLHA with FALTA_ROLHA=1. Then LOAD_CONTADOR with VALOR_CARGA=15 → count 14, VEDADOR_ATIVO=1 for 4 cycles, FALTA_ROLHA=0.
- Count 10, three bottles each present for 8 cycles → count 7, three GARRAFA_VEDADA pulses, TOTAL_VEDADAS=3. Bottle held for 20 cycles yields only one pulse.
- Load VALOR_CARGA=120 → COUNT_ATUAL=99, DEZENA=9, UNIDADE=9. Load 5 → ALERTA_BAIXO=1, DEZENA=0, UNIDADE=5.
- Count 3 in OCIOSO, bottle arrives in the same cycle as a load of 18 → count 17 next cycle, corking starts.
- Assert RESET during the 2nd VEDANDO cycle with the bottle still present → VEDADOR_ATIVO=0 immediately and count 0 after reset. No corking until the bottle is removed and re-presented.
- Force TOTAL_VEDADAS to 1023 via 1023 bottles (fast stimulus), then one more bottle → TOTAL_VEDADAS stays at 1023 and the GARRAFA_VEDADA pulse still occurs.
